// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU.
// Holds the fetch FSM state encoding, opcode constants and the
// default datapath widths used by the fetch controller and friends.
package cpu_pkg;

   localparam int ADDR_W_DEF = 5;
   localparam int DATA_W_DEF = 8;
   localparam int OPC_W_DEF  = 3;

   // fetch FSM state encoding
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_VALID = 2'd2;
   localparam logic [1:0] ST_HALT  = 2'd3;

   // opcode field values (instr[7:5])
   localparam logic [OPC_W_DEF-1:0] OPC_NOP  = 3'b000;
   localparam logic [OPC_W_DEF-1:0] OPC_LDA  = 3'b001;
   localparam logic [OPC_W_DEF-1:0] OPC_ADD  = 3'b010;
   localparam logic [OPC_W_DEF-1:0] OPC_SUB  = 3'b011;
   localparam logic [OPC_W_DEF-1:0] OPC_STA  = 3'b100;
   localparam logic [OPC_W_DEF-1:0] OPC_JMP  = 3'b101;
   localparam logic [OPC_W_DEF-1:0] OPC_JZ   = 3'b110;
   localparam logic [OPC_W_DEF-1:0] OPC_HALT = 3'b111;

endpackage

// File: rtl/pc_counter.sv
// Program counter register.
// Priority: rst > load > inc > hold. Increment wraps modulo 2^ADDR_W.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   load, load_addr  load pc with load_addr
//   inc            pc <= pc + 1
//   pc             current program counter
module pc_counter
   import cpu_pkg::*;
#(
   parameter int              ADDR_W     = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic              inc,
   output logic [ADDR_W-1:0] pc
);

   always_ff @(posedge clk_i) begin
      if (rst_i)
         pc <= RESET_ADDR;
      else if (load)
         pc <= load_addr;
      else if (inc)
         pc <= pc + 1'b1;
   end

endmodule

// File: rtl/rom_fetch_ctrl.sv
// Instruction-fetch controller for the accumulator CPU.
// Owns the PC, addresses the combinational program ROM, captures each
// byte into the IR and hands it to execute over valid/ready at up to
// one instruction per cycle. Supports jump (reload + flush), halt on
// the HALT opcode and start/resume.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i             leave IDLE/HALT and fetch from current PC
//   rom_addr_o          ROM address (= PC, combinational)
//   rom_data_i          ROM data for rom_addr_o
//   instr_o             instruction register
//   instr_addr_o        address instr_o was fetched from
//   instr_valid_o       instr_o awaiting acceptance
//   instr_ready_i       execute accepts instr_o this cycle
//   jump_i, jump_addr_i redirect fetch to jump_addr_i
//   halted_o            high while halted
module rom_fetch_ctrl
   import cpu_pkg::*;
#(
   parameter int                ADDR_W      = ADDR_W_DEF,
   parameter int                DATA_W      = DATA_W_DEF,
   parameter int                OPC_W       = OPC_W_DEF,
   parameter logic [OPC_W-1:0]  HALT_OPCODE = OPC_HALT,
   parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   output logic [ADDR_W-1:0] rom_addr_o,
   input  logic [DATA_W-1:0] rom_data_i,
   output logic [DATA_W-1:0] instr_o,
   output logic [ADDR_W-1:0] instr_addr_o,
   output logic              instr_valid_o,
   input  logic              instr_ready_i,
   input  logic              jump_i,
   input  logic [ADDR_W-1:0] jump_addr_i,
   output logic              halted_o
);

   logic [1:0]        state, state_nxt;
   logic [DATA_W-1:0] ir;
   logic [ADDR_W-1:0] ir_addr;
   logic [ADDR_W-1:0] pc;
   logic              pc_load, pc_inc, capture;
   logic              is_halt;

   assign is_halt = (ir[DATA_W-1 -: OPC_W] == HALT_OPCODE);

   // next-state and datapath control
   always_comb begin
      state_nxt = state;
      pc_load   = 1'b0;
      pc_inc    = 1'b0;
      capture   = 1'b0;
      case (state)
         ST_IDLE, ST_HALT: begin
            if (start_i) state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            if (jump_i) begin
               pc_load = 1'b1;
            end else begin
               capture   = 1'b1;
               pc_inc    = 1'b1;
               state_nxt = ST_VALID;
            end
         end
         ST_VALID: begin
            if (jump_i) begin
               // flush: the presented IR is dropped (transferred if ready)
               pc_load   = 1'b1;
               state_nxt = ST_FETCH;
            end else if (instr_ready_i && is_halt) begin
               // pc already points past the HALT, so resume continues there
               state_nxt = ST_HALT;
            end else if (instr_ready_i) begin
               // refill from the ROM in the same cycle as the transfer
               capture = 1'b1;
               pc_inc  = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= ST_IDLE;
         ir      <= '0;
         ir_addr <= '0;
      end else begin
         state <= state_nxt;
         if (capture) begin
            ir      <= rom_data_i;
            ir_addr <= pc;
         end
      end
   end

   pc_counter #(
      .ADDR_W     (ADDR_W),
      .RESET_ADDR (RESET_ADDR)
   ) u_pc (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .load      (pc_load),
      .load_addr (jump_addr_i),
      .inc       (pc_inc),
      .pc        (pc)
   );

   assign rom_addr_o    = pc;
   assign instr_o       = ir;
   assign instr_addr_o  = ir_addr;
   assign instr_valid_o = (state == ST_VALID);
   assign halted_o      = (state == ST_HALT);

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Bench for rom_fetch_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural
// model of the fetch stream.
module tb_rom_fetch_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       start_i = 1'b0;
   logic [4:0] rom_addr_o;
   logic [7:0] rom_data_i;
   logic [7:0] instr_o;
   logic [4:0] instr_addr_o;
   logic       instr_valid_o;
   logic       instr_ready_i = 1'b0;
   logic       jump_i = 1'b0;
   logic [4:0] jump_addr_i = '0;
   logic       halted_o;

   logic [7:0] rom [32];
   assign rom_data_i = rom[rom_addr_o];

   always #5 clk_i = ~clk_i;

   rom_fetch_ctrl dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .start_i       (start_i),
      .rom_addr_o    (rom_addr_o),
      .rom_data_i    (rom_data_i),
      .instr_o       (instr_o),
      .instr_addr_o  (instr_addr_o),
      .instr_valid_o (instr_valid_o),
      .instr_ready_i (instr_ready_i),
      .jump_i        (jump_i),
      .jump_addr_i   (jump_addr_i),
      .halted_o      (halted_o)
   );

   int n_chk = 0;
   int n_pass = 0;
   bit chk_en = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Behavioural model: the controller is either waiting for start
   // (idle/halted), spending one cycle reading the ROM, or presenting
   // the word at m_addr. The presented word is always rom[m_addr].
   bit m_wait_start, m_halted, m_reading, m_have;
   int m_pc, m_addr;

   always @(posedge clk_i) begin
      if (rst_i) begin
         m_wait_start = 1; m_halted = 0; m_reading = 0; m_have = 0;
         m_pc = 0; m_addr = 0;
      end else if (m_wait_start) begin
         if (start_i) begin m_wait_start = 0; m_halted = 0; m_reading = 1; end
      end else if (m_reading) begin
         if (jump_i) m_pc = jump_addr_i;
         else begin
            m_addr = m_pc; m_pc = (m_pc + 1) % 32;
            m_reading = 0; m_have = 1;
         end
      end else if (m_have) begin
         if (jump_i) begin
            m_pc = jump_addr_i; m_have = 0; m_reading = 1;
         end else if (instr_ready_i) begin
            if (rom[m_addr][7:5] == 3'b111) begin
               m_have = 0; m_wait_start = 1; m_halted = 1;
            end else begin
               m_addr = m_pc; m_pc = (m_pc + 1) % 32;
            end
         end
      end
   end

   // compare process, away from the active edge
   always @(negedge clk_i) begin
      if (chk_en) begin
         chk("m_valid", instr_valid_o, m_have);
         chk("m_halted", halted_o, m_halted);
         chk("m_rom_addr", rom_addr_o, m_pc);
         if (m_have) begin
            chk("m_instr_addr", instr_addr_o, m_addr);
            chk("m_instr", instr_o, rom[m_addr]);
         end
      end
   end

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         rom[i] = 8'($urandom);
         if (rom[i][7:5] == 3'b111 && ($urandom_range(0, 2) != 0)) rom[i][7:5] = 3'b001;
      end
      rom[0] = 8'h21; rom[1] = 8'h42; rom[2] = 8'h63; rom[3] = 8'hE0;
      rom[4] = 8'h05; rom[20] = 8'h3C; rom[31] = 8'h10;

      // reset
      tick;
      chk_en = 1;
      tick;
      chk("rst_valid", instr_valid_o, 0);
      chk("rst_halted", halted_o, 0);
      chk("rst_rom_addr", rom_addr_o, 0);
      chk("rst_instr", instr_o, 0);
      chk("rst_instr_addr", instr_addr_o, 0);

      // basic fetch to HALT
      rst_i = 0; instr_ready_i = 1; start_i = 1;
      tick;
      start_i = 0;
      chk("start_fetch_valid", instr_valid_o, 0);
      for (int i = 0; i < 4; i++) begin
         tick;
         chk("basic_valid", instr_valid_o, 1);
         chk("basic_addr", instr_addr_o, i);
         chk("basic_instr", instr_o, rom[i]);
      end
      chk("basic_instr3", instr_o, 8'hE0);
      tick;
      chk("halt_halted", halted_o, 1);
      chk("halt_valid", instr_valid_o, 0);
      chk("halt_rom_addr", rom_addr_o, 4);
      // jump ignored while halted
      jump_i = 1; jump_addr_i = 5'd9;
      tick;
      jump_i = 0;
      chk("halt_jump_ign", rom_addr_o, 4);

      // resume
      start_i = 1;
      tick;
      start_i = 0;
      tick;
      chk("resume_addr", instr_addr_o, 4);
      chk("resume_instr", instr_o, 8'h05);

      // stall at addr 1, with a start_i that must be ignored
      jump_i = 1; jump_addr_i = 5'd1;
      tick;
      jump_i = 0;
      chk("jmp_flush_valid", instr_valid_o, 0);
      tick;
      instr_ready_i = 0; start_i = 1;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("stall_instr", instr_o, 8'h42);
         chk("stall_addr", instr_addr_o, 1);
         chk("stall_rom_addr", rom_addr_o, 2);
         chk("stall_valid", instr_valid_o, 1);
      end
      start_i = 0; instr_ready_i = 1;
      tick;
      chk("after_stall", instr_o, 8'h63);

      // jump from VALID at addr 1 to 20
      jump_i = 1; jump_addr_i = 5'd1;
      tick;
      jump_i = 0;
      tick;
      chk("pre_jump_addr", instr_addr_o, 1);
      jump_i = 1; jump_addr_i = 5'd20;
      tick;
      jump_i = 0;
      chk("jump_bubble", instr_valid_o, 0);
      chk("jump_rom_addr", rom_addr_o, 20);
      tick;
      chk("jump_addr", instr_addr_o, 20);
      chk("jump_instr", instr_o, 8'h3C);

      // wrap-around 31 -> 0
      jump_i = 1; jump_addr_i = 5'd31;
      tick;
      jump_i = 0;
      tick;
      chk("wrap_addr31", instr_addr_o, 31);
      chk("wrap_instr31", instr_o, 8'h10);
      tick;
      chk("wrap_addr0", instr_addr_o, 0);
      chk("wrap_instr0", instr_o, 8'h21);
      chk("wrap_valid", instr_valid_o, 1);

      // reset in VALID with instr 0x63, together with a jump
      tick;
      tick;
      chk("pre_rst_instr", instr_o, 8'h63);
      rst_i = 1; jump_i = 1; jump_addr_i = 5'd9;
      tick;
      rst_i = 0; jump_i = 0;
      chk("mrst_valid", instr_valid_o, 0);
      chk("mrst_instr", instr_o, 0);
      chk("mrst_rom_addr", rom_addr_o, 0);
      chk("mrst_halted", halted_o, 0);
      // IDLE ignores jump
      jump_i = 1; jump_addr_i = 5'd7;
      tick;
      jump_i = 0;
      chk("idle_jump_ign", rom_addr_o, 0);
      chk("idle_valid", instr_valid_o, 0);

      // randomized traffic
      for (int c = 0; c < 4000; c++) begin
         rst_i         = ($urandom_range(0, 199) == 0);
         start_i       = ($urandom_range(0, 3) == 0);
         jump_i        = ($urandom_range(0, 9) == 0);
         jump_addr_i   = 5'($urandom);
         instr_ready_i = ($urandom_range(0, 3) != 0);
         tick;
      end
      rst_i = 0; start_i = 0; jump_i = 0; instr_ready_i = 0;
      tick;
      @(negedge clk_i);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
